mul_iter_ctrl: RTL and testbench



---
 rtl/mul_pkg.sv | 28 ++
 rtl/mul_iter_ctrl_if.sv | 28 ++
 rtl/rca_adder.sv | 24 ++
 rtl/mul_iter_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mul_iter_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the iterative multiplier controller.
// Holds the FSM state encoding, RV64M func3 codes and default widths.
package mul_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int CNT_W_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    function automatic logic src1_signed(logic [2:0] f);
        return (f == F3_MULH) || (f == F3_MULHSU);
    endfunction

    function automatic logic src2_signed(logic [2:0] f);
        return f == F3_MULH;
    endfunction

endpackage

// File: rtl/mul_iter_ctrl_if.sv
// Issue/writeback handshake bundle for the iterative multiplier.
// master = issue/writeback side, slave = multiplier.
interface mul_iter_ctrl_if #(
    parameter int XLEN = 64
) ();

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      func3;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, func3, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, func3, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/rca_adder.sv
// Ripple-carry adder built as a chain of full-adder cells.
// Shared by the multiply and negate phases of the controller.
module rca_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/mul_iter_ctrl.sv
// Iterative shift-add RV64M multiplier controller (MUL/MULH/MULHSU/MULHU).
// Define MUL_EARLY_OUT_EN to skip CALC once the remaining multiplier bits are zero.
module mul_iter_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_iter_ctrl_if.slave  bus
);

    state_t state;
    state_t state_n;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mult;
    logic [2:0]       f3;
    logic             neg;
    logic             phase;
    logic             carry;

    logic [XLEN-1:0]  add_a;
    logic [XLEN-1:0]  add_b;
    logic [XLEN-1:0]  add_sum;
    logic             add_cin;
    logic             add_cout;

    logic             neg1;
    logic             neg2;
    logic [XLEN-1:0]  mag1;
    logic [XLEN-1:0]  mag2;
    logic             last;
    logic             skip;
    logic             zero2;
    logic [2*XLEN-1:0] step;

    rca_adder #(.W(XLEN)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        neg1 = src1_signed(bus.func3) & bus.src1[XLEN-1];
        neg2 = src2_signed(bus.func3) & bus.src2[XLEN-1];
        mag1 = neg1 ? -bus.src1 : bus.src1;
        mag2 = neg2 ? -bus.src2 : bus.src2;
        last = cnt == CNT_W'(XLEN-1);
    end

`ifdef MUL_EARLY_OUT_EN
    logic [CNT_W-1:0] rem;

    always_comb begin
        skip  = mult[XLEN-1:1] == '0;
        zero2 = mag2 == '0;
        rem   = CNT_W'(XLEN-1) - cnt;
        step  = {add_cout, add_sum, acc_lo[XLEN-1:1]};
        if (skip) begin
            step = step >> rem;
        end
    end
`else
    always_comb begin
        skip  = 1'b0;
        zero2 = 1'b0;
        step  = {add_cout, add_sum, acc_lo[XLEN-1:1]};
    end
`endif

    // CALC adds into the high half; SIGN negates low then high half.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state)
            CALC: begin
                add_a = acc_hi;
                add_b = mult[0] ? mcand : '0;
            end
            SIGN: begin
                add_a   = phase ? ~acc_hi : ~acc_lo;
                add_cin = phase ? carry : 1'b1;
            end
            default: begin
                add_a = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.func3[2])
                            state_n = DONE;
                        else if (zero2)
                            state_n = SIGN;
                        else
                            state_n = CALC;
                    end
                end
                CALC: begin
                    if (last || skip)
                        state_n = SIGN;
                end
                SIGN: begin
                    if (!neg || phase)
                        state_n = DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy      = state != IDLE;
        bus.result    = '0;
        if (state == DONE) begin
            bus.result = (f3 == F3_MUL) ? acc_lo : acc_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            mult   <= '0;
            f3     <= '0;
            neg    <= 1'b0;
            phase  <= 1'b0;
            carry  <= 1'b0;
        end else if (bus.flush) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            phase  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        f3     <= bus.func3;
                        mcand  <= mag1;
                        mult   <= mag2;
                        neg    <= neg1 ^ neg2;
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= '0;
                        phase  <= 1'b0;
                        carry  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_hi <= step[2*XLEN-1:XLEN];
                    acc_lo <= step[XLEN-1:0];
                    mult   <= mult >> 1;
                    cnt    <= cnt + 1'b1;
                end
                SIGN: begin
                    if (neg && !phase) begin
                        acc_lo <= add_sum;
                        carry  <= add_cout;
                        phase  <= 1'b1;
                    end else if (neg) begin
                        acc_hi <= add_sum;
                    end
                end
                default: begin
                    phase <= phase;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// Scoreboard bench for mul_iter_ctrl: random and directed RV64M requests.
// Expected products come from wide signed arithmetic in the reference model.
module tb_mul_iter_ctrl;
    import mul_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul_iter_ctrl_if #(.XLEN(XLEN)) bus ();

    mul_iter_ctrl #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          hs;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seen_hs = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_res(input logic [2:0] f,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [129:0] x;
        logic signed [129:0] y;
        logic signed [129:0] p;
        if (f[2]) return 64'd0;
        x = src1_signed(f) ? $signed({{66{a[63]}}, a}) : $signed({66'd0, a});
        y = src2_signed(f) ? $signed({{66{b[63]}}, b}) : $signed({66'd0, b});
        p = x * y;
        return (f == F3_MUL) ? p[63:0] : p[127:64];
    endfunction

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        bit neg;
        int sgn;
`ifdef MUL_EARLY_OUT_EN
        logic [63:0] mb;
        int h;
`endif
        if (f[2]) return 1;
        neg = (src1_signed(f) && a[63]) != (src2_signed(f) && b[63]);
        sgn = neg ? 2 : 1;
`ifdef MUL_EARLY_OUT_EN
        mb = (src2_signed(f) && b[63]) ? -b : b;
        if (mb == 0) return sgn + 1;
        h = 0;
        for (int i = 0; i < 64; i++)
            if (mb[i]) h = i;
        return h + 1 + sgn + 1;
`else
        return XLEN + sgn + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                if (q[0].hs != seen_hs) begin
                    seen_hs = q[0].hs;
                    chk("latency", 64'(cyc - q[0].hs + 1), 64'(q[0].lat));
                end
                chk("result", bus.result, q[0].res);
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, output bit ok, output int hs);
        int n = 0;
        bus.func3 = f;
        bus.src1 = a;
        bus.src2 = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        ok = bus.in_ready;
        hs = cyc + 1;
        if (!ok) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic push(input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input int hs);
        exp_t e;
        e.res = exp_res(f, a, b);
        e.lat = exp_lat(f, a, b);
        e.hs = hs;
        q.push_back(e);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
        bit ok;
        int hs;
        bus.out_ready = (hold == 0);
        send(f, a, b, ok, hs);
        if (!ok) return;
        push(f, a, b, hs);
        if (hold > 0) begin
            wait_valid();
            repeat (hold) begin
                chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
                tick();
            end
            bus.out_ready = 1'b1;
        end
        wait_idle();
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return ALL1;
            3: return MINV;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        int hs;
        bus.in_valid = 1'b0;
        bus.func3 = 3'd0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        rst_n = 1'b1;
        tick();

        run(F3_MUL, 64'd3, 64'd5, 0);
        run(F3_MULH, ALL1, ALL1, 0);
        run(F3_MUL, ALL1, ALL1, 0);
        run(F3_MULHSU, ALL1, ALL1, 0);
        run(F3_MULHU, ALL1, 64'd2, 5);

        bus.out_ready = 1'b1;
        send(F3_MUL, 64'd123, 64'd456, ok, hs);
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (80) tick();
        run(F3_MUL, 64'd7, 64'd6, 0);

        run(3'b100, 64'd11, 64'd13, 0);
        run(F3_MUL, 64'd9, 64'd1, 0);
        run(F3_MUL, MINV, MINV, 0);
        run(F3_MULH, MINV, MINV, 1);
        run(F3_MULHU, MINV, MINV, 0);
        run(F3_MULH, MINV, 64'd0, 0);

        bus.func3 = F3_MUL;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_vs_req_busy", 64'(bus.busy), 64'd0);

        bus.out_ready = 1'b0;
        send(F3_MULHU, ALL1, ALL1, ok, hs);
        push(F3_MULHU, ALL1, ALL1, hs);
        wait_valid();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        chk("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_done_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        send(F3_MULH, ALL1, 64'd77, ok, hs);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_result", bus.result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 5));
            run(f, pick(), pick(), $urandom_range(0, 2));
        end

        repeat (5) tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
